res_ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port result RAM (16384 × 8, read sampled on negedge, write committed on posedge) between two requesters. Typical requesters are the distance-transform pixel engine on port 0 and a host/readback or second-pass engine on port 1. The block registers the winning transaction onto the RAM pins and returns read data with a fixed latency. A lock mechanism gives one requester exclusive read-modify-write sequences.

---
 rtl/res_ram_arbiter.sv | 114 +++++++++++
 tb/tb_res_ram_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/res_ram_arbiter.sv
// Two-port arbiter for the single-port result RAM, with lock-based RMW ownership.
// Define RES_ARB_RR_EN for round-robin priority; otherwise port 0 has fixed priority.
module res_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   elig0, elig1;
  logic   win0, win1;
  logic   prio1;

`ifdef RES_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win0) ptr_d = 1'b1;
    if (state_q == IDLE && win1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign prio1 = ptr_q && (state_q == IDLE);
`else
  assign prio1 = 1'b0;
`endif

  // The locked-out port is simply never eligible.
  assign elig0 = req0 && (state_q != OWN1);
  assign elig1 = req1 && (state_q != OWN0);
  assign win1  = elig1 && (!elig0 || prio1);
  assign win0  = elig0 && !win1;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      win0:    state_d = lock0 ? OWN0 : IDLE;
      win1:    state_d = lock1 ? OWN1 : IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign owner = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else begin
      gnt0   <= win0;
      gnt1   <= win1;
      res_rd <= (win0 && !we0) || (win1 && !we1);
      res_wr <= (win0 && we0) || (win1 && we1);
      if (win0) begin
        res_addr <= addr0;
        if (we0) res_do <= wdata0;
      end else if (win1) begin
        res_addr <= addr1;
        if (we1) res_do <= wdata1;
      end
      // gntN in the read cycle identifies which port issued it.
      rvalid0 <= res_rd && gnt0;
      rvalid1 <= res_rd && gnt1;
      if (res_rd) rdata <= res_di;
    end
  end

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Self-checking bench for res_ram_arbiter: directed table, contention,
// reset mid-read and randomized traffic against a transaction-level model.
module tb_res_ram_arbiter;

`ifdef RES_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [13:0] addr0 = 0, addr1 = 0;
  logic [7:0]  wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, res_rd, res_wr;
  logic [7:0]  rdata, res_do;
  logic [7:0]  res_di = 0;
  logic [13:0] res_addr;
  logic [1:0]  owner;

  res_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .res_rd(res_rd), .res_wr(res_wr),
    .res_addr(res_addr), .res_do(res_do), .res_di(res_di),
    .owner(owner)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:16383];
  always @(negedge clk) if (res_rd) res_di <= mem[res_addr];
  always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: who owns the RAM, RR pointer, shadow memory, pending read.
  logic [7:0] sh [0:16383];
  int         m_own = 0;
  int         m_ptr = 0;
  int         pv_port = -1;
  logic [7:0] pv_data = 0;
  logic [7:0] m_rdata = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_ptr = 0; pv_port = -1; m_rdata = 0;
  endtask

  task automatic tick();
    int w;
    bit e0, e1, t_we, t_lk;
    logic [13:0] t_a;
    logic [7:0]  t_d;
    e0 = req0 && m_own != 2;
    e1 = req1 && m_own != 1;
    w = -1;
    if (e0 && e1)  w = RR ? m_ptr : 0;
    else if (e0)   w = 0;
    else if (e1)   w = 1;
    t_we = (w == 1) ? we1 : we0;
    t_lk = (w == 1) ? lock1 : lock0;
    t_a  = (w == 1) ? addr1 : addr0;
    t_d  = (w == 1) ? wdata1 : wdata0;
    @(posedge clk); #1;
    cyc++;
    chk("gnt0", 32'(gnt0), 32'(w == 0));
    chk("gnt1", 32'(gnt1), 32'(w == 1));
    chk("rvalid0", 32'(rvalid0), 32'(pv_port == 0));
    chk("rvalid1", 32'(rvalid1), 32'(pv_port == 1));
    if (pv_port >= 0) m_rdata = pv_data;
    chk("rdata", 32'(rdata), 32'(m_rdata));
    pv_port = -1;
    if (w >= 0) begin
      chk("res_rd", 32'(res_rd), 32'(!t_we));
      chk("res_wr", 32'(res_wr), 32'(t_we));
      chk("res_addr", 32'(res_addr), 32'(t_a));
      if (t_we) begin
        chk("res_do", 32'(res_do), 32'(t_d));
        sh[t_a] = t_d;
      end else begin
        pv_port = w;
        pv_data = sh[t_a];
      end
      if (m_own == 0) m_ptr = 1 - w;
      m_own = t_lk ? w + 1 : 0;
    end else begin
      chk("res_rd_idle", 32'(res_rd), 0);
      chk("res_wr_idle", 32'(res_wr), 0);
    end
    chk("owner", 32'(owner), m_own);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  typedef struct {
    bit r0, w0, l0; logic [13:0] a0; logic [7:0] d0;
    bit r1, w1, l1; logic [13:0] a1; logic [7:0] d1;
    bit g0, g1; logic [1:0] own; bit rv0, rv1; logic [7:0] rd;
  } vec_t;

  vec_t tv [14];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 8'($urandom);
      sh[i]  = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'(i + 1);
      sh[i]  = 8'(i + 1);
    end
    mem[16'h0100] = 8'h33;
    sh[16'h0100]  = 8'h33;

    tv[0]  = '{1,1,0,14'h1234,8'h5a, 0,0,0,14'h0,8'h0,  1,0,2'b00,0,0,8'h00};
    tv[1]  = '{1,0,0,14'h1234,8'h00, 0,0,0,14'h0,8'h0,  1,0,2'b00,0,0,8'h00};
    tv[2]  = '{0,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  0,0,2'b00,1,0,8'h5a};
    tv[3]  = '{0,0,0,14'h0,8'h00,    1,0,1,14'h0100,8'h0, 0,1,2'b10,0,0,8'h00};
    tv[4]  = '{1,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  0,0,2'b10,0,1,8'h33};
    tv[5]  = '{1,0,0,14'h0,8'h00,    1,1,0,14'h0100,8'h07, 0,1,2'b00,0,0,8'h00};
    tv[6]  = '{1,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  1,0,2'b00,0,0,8'h00};
    tv[7]  = '{1,0,0,14'h0100,8'h00, 0,0,0,14'h0,8'h0,  1,0,2'b00,1,0,8'h01};
    tv[8]  = '{0,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  0,0,2'b00,1,0,8'h07};
    tv[9]  = '{1,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  1,0,2'b00,0,0,8'h00};
    tv[10] = '{1,0,0,14'h1,8'h00,    0,0,0,14'h0,8'h0,  1,0,2'b00,1,0,8'h01};
    tv[11] = '{1,0,0,14'h2,8'h00,    0,0,0,14'h0,8'h0,  1,0,2'b00,1,0,8'h02};
    tv[12] = '{1,0,0,14'h3,8'h00,    0,0,0,14'h0,8'h0,  1,0,2'b00,1,0,8'h03};
    tv[13] = '{0,0,0,14'h0,8'h00,    0,0,0,14'h0,8'h0,  0,0,2'b00,1,0,8'h04};

    do_reset();
    @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1, rvalid0, rvalid1}), 0);
    chk("rst_ram", 32'({res_rd, res_wr, res_addr, res_do}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_owner", 32'(owner), 0);

    for (int i = 0; i < 14; i++) begin
      req0 = tv[i].r0; we0 = tv[i].w0; lock0 = tv[i].l0;
      addr0 = tv[i].a0; wdata0 = tv[i].d0;
      req1 = tv[i].r1; we1 = tv[i].w1; lock1 = tv[i].l1;
      addr1 = tv[i].a1; wdata1 = tv[i].d1;
      tick();
      chk($sformatf("tv%0d_gnt", i), 32'({gnt0, gnt1}), 32'({tv[i].g0, tv[i].g1}));
      chk($sformatf("tv%0d_own", i), 32'(owner), 32'(tv[i].own));
      chk($sformatf("tv%0d_rv", i), 32'({rvalid0, rvalid1}),
          32'({tv[i].rv0, tv[i].rv1}));
      if (tv[i].rv0 || tv[i].rv1)
        chk($sformatf("tv%0d_rdata", i), 32'(rdata), 32'(tv[i].rd));
    end

    // Continuous contention from a fresh reset.
    do_reset();
    req0 = 1; we0 = 0; lock0 = 0; addr0 = 14'h0000;
    req1 = 1; we1 = 0; lock1 = 0; addr1 = 14'h3fff;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cont%0d_gnt0", i), 32'(gnt0), 32'(RR ? (i % 2 == 0) : 1'b1));
    end
    req0 = 0; req1 = 0;
    tick();

    // Reset asserted during the res_rd cycle.
    req0 = 1; we0 = 0; lock0 = 1; addr0 = 14'h0002;
    tick();
    #1 reset = 1'b0;
    req0 = 0;
    model_reset();
    #1;
    chk("midrst_out", 32'({gnt0, gnt1, rvalid0, rvalid1, res_rd, res_wr}), 0);
    chk("midrst_bus", 32'({res_addr, res_do}), 0);
    chk("midrst_rdata", 32'(rdata), 0);
    chk("midrst_owner", 32'(owner), 0);
    @(posedge clk); #1;
    chk("midrst_rv", 32'(rvalid0), 0);
    reset = 1'b1;
    tick();
    chk("postrst_rv", 32'(rvalid0), 0);
    req0 = 1; we0 = 0; lock0 = 0; addr0 = 14'h0003;
    tick();
    chk("postrst_gnt", 32'(gnt0), 1);
    req0 = 0;
    tick();
    chk("postrst_rdata", 32'(rdata), 32'h04);

    // Randomized traffic obeying the hold-until-grant contract.
    for (int n = 0; n < 400; n++) begin
      if (gnt0 || !req0) begin
        req0 = ($urandom_range(0, 9) < 6);
        we0 = 1'($urandom_range(0, 1));
        lock0 = ($urandom_range(0, 3) == 0);
        addr0 = 14'($urandom_range(0, 15));
        wdata0 = 8'($urandom);
      end
      if (gnt1 || !req1) begin
        req1 = ($urandom_range(0, 9) < 6);
        we1 = 1'($urandom_range(0, 1));
        lock1 = ($urandom_range(0, 3) == 0);
        addr1 = 14'($urandom_range(0, 15));
        wdata1 = 8'($urandom);
      end
      tick();
    end
    req0 = 0; req1 = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
